// File: rtl/teamd_rx_word_fifo.sv
// teamd_rx_word_fifo
//   Receive-side show-ahead FIFO placed behind the TEAMD asynchronous serial
//   interface. A word is captured on the rising edge of iLoad. Stored words
//   are handed to the consumer with a valid/request handshake. The block also
//   reports its occupancy and a sticky overrun flag.
//
// Ports
//   CLK      system clock; all state changes on the rising edge
//   Reset    synchronous, active-high reset
//   iD       received word (iD[0] = iD0 ... iD[6] = iD6)
//   iLoad    word-ready level from the serial interface control unit
//   RdReq    consumer pop request; ignored while empty
//   ClrOvr   clears Overrun (a drop on the same edge wins)
//   RdData   head-of-FIFO word, 0 when RdValid is low
//   RdValid  FIFO non-empty
//   Count    occupancy, 0..DEPTH
//   Full     Count == DEPTH
//   Empty    Count == 0
//   Overrun  sticky: a word was dropped because the FIFO was full
module teamd_rx_word_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         iD,
  input  logic                     iLoad,
  input  logic                     RdReq,
  input  logic                     ClrOvr,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdValid,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty,
  output logic                     Overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             load_d;
  logic             ovr;

  logic             push;
  logic             pop;
  logic             is_full;
  logic             not_empty;
  logic             wr_en;
  logic             drop;

  // load_d resets high so that an iLoad level held through reset release
  // does not look like a rising edge.
  always_comb begin
    is_full   = (count == CW'(DEPTH));
    not_empty = (count != '0);
    push      = iLoad & ~load_d;
    pop       = RdReq & not_empty;
    // When full, a same-edge pop frees the head slot. wr_ptr equals rd_ptr
    // in that case, so the new word overwrites the word that is leaving.
    wr_en     = push & (~is_full | pop);
    drop      = push & is_full & ~pop;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      load_d <= 1'b1;
      ovr    <= 1'b0;
    end else begin
      load_d <= iLoad;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)        ovr <= 1'b1;
      else if (ClrOvr) ovr <= 1'b0;
    end
  end

  // The storage array needs no reset: its contents are only visible while
  // the count says they are valid.
  always_ff @(posedge CLK) begin
    if (!Reset && wr_en) mem[wr_ptr] <= iD;
  end

  always_comb begin
    RdValid = not_empty;
    RdData  = not_empty ? mem[rd_ptr] : '0;
    Count   = count;
    Full    = is_full;
    Empty   = ~not_empty;
    Overrun = ovr;
  end

endmodule

// File: tb/tb_teamd_rx_word_fifo.sv
module tb_teamd_rx_word_fifo;

  localparam int WIDTH = 7;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] iD;
  logic             iLoad;
  logic             RdReq;
  logic             ClrOvr;
  logic [WIDTH-1:0] RdData;
  logic             RdValid;
  logic [2:0]       Count;
  logic             Full;
  logic             Empty;
  logic             Overrun;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb [$];
  logic             ovr_exp = 1'b0;

  teamd_rx_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .iD(iD), .iLoad(iLoad), .RdReq(RdReq),
    .ClrOvr(ClrOvr), .RdData(RdData), .RdValid(RdValid), .Count(Count),
    .Full(Full), .Empty(Empty), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after an edge; outputs are read there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Single iLoad pulse; the scoreboard records whether the word fits.
  task automatic push_word(input logic [WIDTH-1:0] w);
    iD = w;
    iLoad = 1'b1;
    tick();
    if (sb.size() < DEPTH) sb.push_back(w);
    else ovr_exp = 1'b1;
    iLoad = 1'b0;
    tick();
  endtask

  task automatic test_drain(input string tag);
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (RdValid !== 1'b1 || RdData !== sb[0]) begin
        errors++;
        $display("FAIL %s head[%0d]: got valid=%b data=%h, want valid=1 data=%h",
                 tag, i, RdValid, RdData, sb[0]);
      end
      RdReq = 1'b1;
      tick();
      void'(sb.pop_front());
      RdReq = 1'b0;
    end
    checks++;
    if (Empty !== 1'b1 || RdValid !== 1'b0 || RdData !== '0 || Count !== 3'd0) begin
      errors++;
      $display("FAIL %s drained: got empty=%b valid=%b data=%h count=%0d, want 1 0 00 0",
               tag, Empty, RdValid, RdData, Count);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; iLoad = 1'b1; iD = 7'h33; RdReq = 1'b0; ClrOvr = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    checks++;
    if (Count !== 3'd0 || Empty !== 1'b1 || RdValid !== 1'b0 || RdData !== '0 ||
        Overrun !== 1'b0 || Full !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got count=%0d empty=%b valid=%b data=%h ovr=%b full=%b, want 0 1 0 00 0 0",
               Count, Empty, RdValid, RdData, Overrun, Full);
    end
    iLoad = 1'b0;
    tick();
    checks++;
    if (Count !== 3'd0) begin
      errors++;
      $display("FAIL reset_iload_fall: got count=%0d, want 0", Count);
    end
  endtask

  task automatic test_single();
    iD = 7'h55;
    iLoad = 1'b1;
    tick();
    sb.push_back(7'h55);
    checks++;
    if (RdValid !== 1'b1 || RdData !== 7'h55 || Count !== 3'd1) begin
      errors++;
      $display("FAIL single_latency: got valid=%b data=%h count=%0d, want 1 55 1",
               RdValid, RdData, Count);
    end
    iD = 7'h66;
    tick();
    tick();
    iLoad = 1'b0;
    tick();
    checks++;
    if (Count !== 3'd1 || RdData !== 7'h55) begin
      errors++;
      $display("FAIL single_one_push: got count=%0d data=%h, want 1 55", Count, RdData);
    end
    test_drain("single");
  endtask

  task automatic test_fill_order();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 4; k++) push_word(7'(k + 16 * r));
      checks++;
      if (Full !== 1'b1 || Count !== 3'd4 || Empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_full[%0d]: got full=%b count=%0d empty=%b, want 1 4 0",
                 r, Full, Count, Empty);
      end
      test_drain("fill_order");
    end
  endtask

  task automatic test_overrun();
    for (int k = 1; k <= 4; k++) push_word(7'(k));
    push_word(7'h7F);
    checks++;
    if (Overrun !== ovr_exp || Overrun !== 1'b1 || Count !== 3'd4 || RdData !== 7'h01) begin
      errors++;
      $display("FAIL overrun_drop: got ovr=%b count=%0d head=%h, want 1 4 01",
               Overrun, Count, RdData);
    end
    ClrOvr = 1'b1;
    tick();
    ClrOvr = 1'b0;
    ovr_exp = 1'b0;
    checks++;
    if (Overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got ovr=%b, want 0", Overrun);
    end
    iD = 7'h7E;
    iLoad = 1'b1;
    ClrOvr = 1'b1;
    tick();
    ovr_exp = 1'b1;
    iLoad = 1'b0;
    ClrOvr = 1'b0;
    checks++;
    if (Overrun !== 1'b1 || Count !== 3'd4) begin
      errors++;
      $display("FAIL overrun_set_wins: got ovr=%b count=%0d, want 1 4", Overrun, Count);
    end
    tick();
    ClrOvr = 1'b1;
    tick();
    ClrOvr = 1'b0;
    ovr_exp = 1'b0;
    test_drain("overrun");
  endtask

  task automatic test_full_push_pop();
    for (int k = 1; k <= 4; k++) push_word(7'(k));
    iD = 7'h2A;
    iLoad = 1'b1;
    RdReq = 1'b1;
    tick();
    void'(sb.pop_front());
    sb.push_back(7'h2A);
    iLoad = 1'b0;
    RdReq = 1'b0;
    checks++;
    if (Count !== 3'd4 || Overrun !== 1'b0 || RdData !== 7'h02) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d ovr=%b head=%h, want 4 0 02",
               Count, Overrun, RdData);
    end
    tick();
    test_drain("full_push_pop");
  endtask

  task automatic test_back_to_back();
    push_word(7'h11);
    iD = 7'h22;
    iLoad = 1'b1;
    RdReq = 1'b1;
    tick();
    void'(sb.pop_front());
    sb.push_back(7'h22);
    iLoad = 1'b0;
    RdReq = 1'b0;
    checks++;
    if (Count !== 3'd1 || RdValid !== 1'b1 || RdData !== 7'h22) begin
      errors++;
      $display("FAIL one_push_pop: got count=%0d valid=%b data=%h, want 1 1 22",
               Count, RdValid, RdData);
    end
    tick();
    test_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    push_word(7'h0A);
    push_word(7'h0B);
    push_word(7'h0C);
    ovr_exp = 1'b0;
    iD = 7'h0D;
    iLoad = 1'b1;
    RdReq = 1'b1;
    Reset = 1'b1;
    tick();
    sb.delete();
    Reset = 1'b0;
    RdReq = 1'b0;
    checks++;
    if (Count !== 3'd0 || Empty !== 1'b1 || Full !== 1'b0 || RdValid !== 1'b0 ||
        RdData !== '0 || Overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got count=%0d empty=%b full=%b valid=%b data=%h ovr=%b, want 0 1 0 0 00 0",
               Count, Empty, Full, RdValid, RdData, Overrun);
    end
    tick();
    iLoad = 1'b0;
    tick();
    checks++;
    if (Count !== 3'd0 || RdValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_push: got count=%0d valid=%b, want 0 0", Count, RdValid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_overrun();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
